block_fill_controller: RTL and testbench
========================================

# block_fill_controller

Miss-handling initiator between the data cache and backing data memory. On a cache read miss, it fetches the enclosing block from data memory one word per handshake and hands the assembled block to the cache in a single fill cycle. It also forwards every store to memory as a write-through. It stalls the core for the duration of either transaction.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits
- ADDRESS_WIDTH, 30, word address width (byte address bits [1:0] already stripped)
- BLOCK_SIZE, 2, log2 of words per block (N = 2**BLOCK_SIZE)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core issues a load/store this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDRESS_WIDTH  word address of access
- req_wdata  in  DATA_WIDTH  store data (already byte-merged)
- miss  in  1  cache tag-compare result for req_addr
- stall  out  1  core must hold its request
- fill_valid  out  1  one-cycle strobe: write fill_data into cache
- fill_addr  out  ADDRESS_WIDTH  block base address (low BLOCK_SIZE bits zero)
- fill_data  out  DATA_WIDTH*N  assembled block, word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  ADDRESS_WIDTH  word address to memory
- mem_wdata  out  DATA_WIDTH  write data to memory
- mem_ack  in  1  memory accepts/completes the request this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_req & mem_ack & !mem_we

## Operation
- States: IDLE, READ, FILL, WRITE.
- IDLE:
  - req_valid & req_write → WRITE; latch req_addr and req_wdata.
  - Else req_valid & miss → READ; latch base = req_addr with low BLOCK_SIZE bits cleared; latch start offset; beat counter = 0.
  - Store wins over miss.
- READ:
  - Drive mem_req=1, mem_we=0, mem_addr = base + ((start + beat) mod N).
  - Handshake completes on a rising edge with mem_req & mem_ack. On completion, store mem_rdata into buffer slot (start + beat) mod N.
  - If beat == N-1 → FILL; else beat+1.
  - No ack → hold all mem outputs stable.
- FILL: fill_valid=1, fill_addr=base, fill_data=buffer; → IDLE unconditionally.
- WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values; on ack → IDLE. Cache update on a store hit is the cache's job; this block does not allocate on a store miss.
- Stall:
  - Combinational: stall = (state != IDLE) | (req_valid & (req_write | miss)).
  - In IDLE with a qualifying request, stall rises in the same cycle.
- mem_ack while mem_req=0 is ignored. mem_rdata is ignored outside READ completion.
- Beat counter width is BLOCK_SIZE bits. The offset wraps mod N and never indexes outside the block.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, beat=0, buffer=0; stall=0 (absent request), fill_valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill_addr=0, fill_data=0.
- Reset mid-READ/WRITE: mem_req drops immediately, the partial block is discarded, and no fill_valid is issued.
- Read miss with zero-wait memory (ack same cycle as req):
  - Detect at cycle 0; READ beats at cycles 1..N; FILL at cycle N+1; IDLE at cycle N+2.
  - stall is high for N+2 cycles (6 for N=4).
  - Each cycle without ack adds one cycle.
- Store with zero-wait memory: stall is high for 2 cycles (detect + WRITE).
- A request arriving in the cycle after FILL is evaluated normally. A back-to-back miss restarts READ with no idle bubble beyond that IDLE cycle.
- mem outputs are registered from state/latches, with no combinational path from mem_ack to mem_req.

## Configuration
- CRITICAL_WORD_FIRST_EN defined: start = req_addr[BLOCK_SIZE-1:0]; the first read beat fetches the requested word, then offsets wrap (e.g. offset 2, N=4: 2,3,0,1).
- Undefined: start fixed to 0; beats always fetch offsets 0..N-1 in order.
- fill_data layout and total latency are identical in both builds.

## Test plan
- Reset during READ beat 2 (mem_ack held low) → mem_req=0 immediately, no fill_valid, state IDLE after release; a subsequent miss to 0x10 refetches all 4 words from 0x10.
- Load miss at 0x0000_0012, N=4, ack always 1, memory word[a]=a*3 → mem_addr 0x10,0x11,0x12,0x13 (without macro) or 0x12,0x13,0x10,0x11 (with macro); one fill_valid with fill_addr=0x10, fill_data words {0x30,0x33,0x36,0x39}; stall high exactly 6 cycles.
- Same miss with mem_ack low for 3 cycles on the first beat → mem_addr held stable through the wait; stall high 9 cycles; fill_data unchanged.
- Store req_addr=0x20, req_wdata=0xDEADBEEF, miss=1 → single mem_req with mem_we=1, addr 0x20, data 0xDEADBEEF; no READ, no fill_valid; stall high 2 cycles.
- req_valid, req_write=0, miss=0 → stall=0, mem_req never asserts.
- Back-to-back misses at 0x04 then 0x08 → two fills, fill_addr 0x04 then 0x08; second READ starts the cycle after the intervening IDLE.

Source files
------------

// File: rtl/block_fill_controller.sv
// Cache miss initiator: fetches a block one word per handshake, fills the cache in one cycle, and writes stores through.
// Optional build macro CRITICAL_WORD_FIRST_EN: fetch starts at the requested word and wraps within the block.
module block_fill_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  input  logic                              req_write,
  input  logic [ADDRESS_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  input  logic                              miss,
  output logic                              stall,
  output logic                              fill_valid,
  output logic [ADDRESS_WIDTH-1:0]          fill_addr,
  output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] fill_data,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDRESS_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_ack,
  input  logic [DATA_WIDTH-1:0]             mem_rdata
);

  localparam int N = 2**BLOCK_SIZE;

  typedef enum logic [1:0] {IDLE, READ, FILL, WRITE} state_t;

  state_t                          state;
  logic [BLOCK_SIZE-1:0]           beat;
  logic [BLOCK_SIZE-1:0]           start;
  logic [ADDRESS_WIDTH-BLOCK_SIZE-1:0] base_hi;
  logic [BLOCK_SIZE-1:0]           start_next;
  logic [BLOCK_SIZE-1:0]           slot;
  logic [BLOCK_SIZE-1:0]           slot_next;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_next = req_addr[BLOCK_SIZE-1:0];
`else
  assign start_next = '0;
`endif

  // Offsets are BLOCK_SIZE bits wide, so the sums wrap inside the block.
  assign slot      = start + beat;
  assign slot_next = start + beat + 1'b1;

  assign stall = (state != IDLE) | (req_valid & (req_write | miss));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      start      <= '0;
      base_hi    <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      fill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_write) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
          end else if (req_valid && miss) begin
            state    <= READ;
            base_hi  <= req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE];
            start    <= start_next;
            beat     <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], start_next};
          end
        end
        READ: begin
          // mem_req is always high here, so mem_ack alone completes the beat.
          if (mem_ack) begin
            for (int k = 0; k < N; k++) begin
              if (slot == BLOCK_SIZE'(k)) begin
                fill_data[k*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
              end
            end
            if (&beat) begin
              state      <= FILL;
              beat       <= '0;
              mem_req    <= 1'b0;
              fill_valid <= 1'b1;
              fill_addr  <= {base_hi, {BLOCK_SIZE{1'b0}}};
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= {base_hi, slot_next};
            end
          end
        end
        FILL: begin
          state <= IDLE;
        end
        WRITE: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_fill_controller.sv
// Scoreboard bench for block_fill_controller: memory beats and fills are checked against queued expectations.
module tb_block_fill_controller;

  localparam int DW = 32;
  localparam int AW = 30;
  localparam int BS = 2;
  localparam int N  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic              miss = 1'b0;
  logic              stall;
  logic              fill_valid;
  logic [AW-1:0]     fill_addr;
  logic [DW*N-1:0]   fill_data;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ack = 1'b1;
  logic [DW-1:0]     mem_rdata;

  block_fill_controller #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .miss(miss), .stall(stall),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word[a] = a*3.
  assign mem_rdata = DW'({2'b00, mem_addr} * 32'd3);

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } mem_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW*N-1:0] data; } fill_exp_t;

  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit sb_en    = 1'b1;

  logic          prev_req = 1'b0;
  logic          prev_ack = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_we = 1'b0;
  logic [DW-1:0] prev_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pops one expectation per handshake or fill.
  always @(negedge clk) begin
    mem_exp_t  me;
    fill_exp_t fe;
    if (sb_en && rst_n) begin
      if (mem_req && mem_ack) begin
        n_checks++;
        if (mem_q.size() == 0) begin
          n_fail++;
          $display("FAIL mem_unexpected: got we=%b addr=%h data=%h, required no request", mem_we, mem_addr, mem_wdata);
        end else begin
          me = mem_q.pop_front();
          if (mem_we !== me.we || mem_addr !== me.addr || (me.we && mem_wdata !== me.data)) begin
            n_fail++;
            $display("FAIL mem_beat: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                     mem_we, mem_addr, mem_wdata, me.we, me.addr, me.data);
          end else begin
            $display("mem beat  cyc=%0d we=%b addr=%h data=%h", cyc, mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata);
          end
        end
      end
      if (fill_valid) begin
        n_checks++;
        if (fill_q.size() == 0) begin
          n_fail++;
          $display("FAIL fill_unexpected: got addr=%h data=%h, required no fill", fill_addr, fill_data);
        end else begin
          fe = fill_q.pop_front();
          if (fill_addr !== fe.addr || fill_data !== fe.data) begin
            n_fail++;
            $display("FAIL fill: got addr=%h data=%h, required addr=%h data=%h", fill_addr, fill_data, fe.addr, fe.data);
          end else begin
            $display("fill      cyc=%0d addr=%h data=%h", cyc, fill_addr, fill_data);
          end
        end
      end
      if (prev_req && !prev_ack && mem_req) begin
        n_checks++;
        if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata) begin
          n_fail++;
          $display("FAIL mem_hold: got addr=%h we=%b data=%h, required addr=%h we=%b data=%h",
                   mem_addr, mem_we, mem_wdata, prev_addr, prev_we, prev_wdata);
        end
      end
    end
    prev_req   = mem_req && rst_n;
    prev_ack   = mem_ack;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
  end

  // Pushes expectations for a miss, then drives it from a posedge+1 entry point until the fill cycle ends.
  task automatic miss_run(input logic [AW-1:0] addr, input int waits, input bit chain, input logic [AW-1:0] chain_addr,
                          output int stall_cnt, output int fills, output int fill_cyc, output int first_req_cyc);
    logic [AW-1:0]   base;
    logic [BS-1:0]   st;
    logic [BS-1:0]   off;
    logic [DW*N-1:0] blk;
    mem_exp_t        me;
    fill_exp_t       fe;
    int              waits_left;
    base = {addr[AW-1:BS], 2'b00};
`ifdef CRITICAL_WORD_FIRST_EN
    st = addr[BS-1:0];
`else
    st = '0;
`endif
    for (int i = 0; i < N; i++) begin
      off = st + BS'(i);
      me.we = 1'b0; me.addr = base + AW'(off); me.data = '0;
      mem_q.push_back(me);
    end
    for (int k = 0; k < N; k++) blk[k*DW +: DW] = DW'({2'b00, base + AW'(k)} * 32'd3);
    fe.addr = base; fe.data = blk;
    fill_q.push_back(fe);

    req_valid = 1'b1; req_write = 1'b0; miss = 1'b1; req_addr = addr; req_wdata = '0;
    stall_cnt = 0; fills = 0; fill_cyc = -1; first_req_cyc = -1; waits_left = waits;
    for (int c = 0; c < 40; c++) begin
      if (mem_req && !mem_we && waits_left > 0) begin
        mem_ack = 1'b0; waits_left--;
      end else begin
        mem_ack = 1'b1;
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      if (mem_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (fill_valid) begin fills++; fill_cyc = cyc; end
      @(posedge clk); #1;
      if (fills > 0) break;
    end
    mem_ack = 1'b1;
    if (chain) req_addr = chain_addr;
    else begin req_valid = 1'b0; miss = 1'b0; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (stall !== 1'b0)      begin n_fail++; $display("FAIL reset_stall: got %b, required 0", stall); end
    n_checks++; if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fill_valid: got %b, required 0", fill_valid); end
    n_checks++; if (mem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_req: got %b, required 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
    n_checks++; if (mem_addr !== '0)     begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
    n_checks++; if (mem_wdata !== '0)    begin n_fail++; $display("FAIL reset_mem_wdata: got %h, required 0", mem_wdata); end
    n_checks++; if (fill_addr !== '0)    begin n_fail++; $display("FAIL reset_fill_addr: got %h, required 0", fill_addr); end
    n_checks++; if (fill_data !== '0)    begin n_fail++; $display("FAIL reset_fill_data: got %h, required 0", fill_data); end
    $display("reset     outputs checked");
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss();
    int sc, fl, fc, rc;
    @(posedge clk); #1;
    miss_run(30'h12, 0, 1'b0, '0, sc, fl, fc, rc);
    @(negedge clk);
    n_checks++; if (sc !== 6)  begin n_fail++; $display("FAIL miss_stall_cycles: got %0d, required 6", sc); end
    n_checks++; if (fl !== 1)  begin n_fail++; $display("FAIL miss_fill_count: got %0d, required 1", fl); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL miss_stall_after: got %b, required 0", stall); end
    n_checks++; if (mem_q.size() != 0) begin n_fail++; $display("FAIL miss_beats_left: got %0d, required 0", mem_q.size()); end
  endtask

  task automatic test_wait_states();
    int sc, fl, fc, rc;
    @(posedge clk); #1;
    miss_run(30'h12, 3, 1'b0, '0, sc, fl, fc, rc);
    @(negedge clk);
    n_checks++; if (sc !== 9)  begin n_fail++; $display("FAIL wait_stall_cycles: got %0d, required 9", sc); end
    n_checks++; if (fl !== 1)  begin n_fail++; $display("FAIL wait_fill_count: got %0d, required 1", fl); end
    n_checks++; if (mem_q.size() != 0) begin n_fail++; $display("FAIL wait_beats_left: got %0d, required 0", mem_q.size()); end
  endtask

  task automatic test_store();
    mem_exp_t me;
    int sc, fl, rd;
    bit done;
    @(posedge clk); #1;
    me.we = 1'b1; me.addr = 30'h20; me.data = 32'hDEADBEEF;
    mem_q.push_back(me);
    req_valid = 1'b1; req_write = 1'b1; miss = 1'b1; req_addr = 30'h20; req_wdata = 32'hDEADBEEF; mem_ack = 1'b1;
    sc = 0; fl = 0; rd = 0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall) sc++;
      if (fill_valid) fl++;
      if (mem_req && !mem_we) rd++;
      if (mem_req && mem_ack && mem_we) done = 1'b1;
      @(posedge clk); #1;
      if (done) break;
    end
    req_valid = 1'b0; req_write = 1'b0; miss = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (fill_valid) fl++;
      if (mem_req) rd++;
    end
    n_checks++; if (sc !== 2) begin n_fail++; $display("FAIL store_stall_cycles: got %0d, required 2", sc); end
    n_checks++; if (fl !== 0) begin n_fail++; $display("FAIL store_fill_count: got %0d, required 0", fl); end
    n_checks++; if (rd !== 0) begin n_fail++; $display("FAIL store_extra_requests: got %0d, required 0", rd); end
    n_checks++; if (mem_q.size() != 0) begin n_fail++; $display("FAIL store_not_issued: got %0d pending, required 0", mem_q.size()); end
  endtask

  task automatic test_hit();
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; miss = 1'b0; req_addr = 30'h33;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++; $display("FAIL hit_idle: got stall=%b mem_req=%b, required 0/0", stall, mem_req);
      end else begin
        $display("hit       cyc=%0d stall=0 mem_req=0", cyc);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sc1, fl1, fc1, rc1, sc2, fl2, fc2, rc2;
    @(posedge clk); #1;
    miss_run(30'h04, 0, 1'b1, 30'h08, sc1, fl1, fc1, rc1);
    miss_run(30'h08, 0, 1'b0, '0, sc2, fl2, fc2, rc2);
    @(negedge clk);
    n_checks++; if (fl1 !== 1 || fl2 !== 1) begin n_fail++; $display("FAIL b2b_fills: got %0d,%0d, required 1,1", fl1, fl2); end
    n_checks++; if (rc2 - fc1 !== 2) begin n_fail++; $display("FAIL b2b_gap: got %0d, required 2", rc2 - fc1); end
    n_checks++; if (sc2 !== 6) begin n_fail++; $display("FAIL b2b_stall2: got %0d, required 6", sc2); end
    n_checks++; if (fill_q.size() != 0) begin n_fail++; $display("FAIL b2b_fills_left: got %0d, required 0", fill_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    int hs, fl, rq, sc, fc, rc, fl2;
    sb_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; miss = 1'b1; req_addr = 30'h10; mem_ack = 1'b1;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req && mem_ack) hs++;
      if (hs == 2) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_beat2: got mem_req=%b, required 1", mem_req); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || fill_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got mem_req=%b fill_valid=%b, required 0/0", mem_req, fill_valid);
    end
    req_valid = 1'b0; miss = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    fl = 0; rq = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (fill_valid) fl++;
      if (mem_req || stall) rq++;
    end
    n_checks++; if (fl !== 0 || rq !== 0) begin n_fail++; $display("FAIL rst_after: got fills=%0d active=%0d, required 0/0", fl, rq); end
    $display("reset     mid-read discarded");
    sb_en = 1'b1;
    @(posedge clk); #1;
    miss_run(30'h10, 0, 1'b0, '0, sc, fl2, fc, rc);
    @(negedge clk);
    n_checks++; if (fl2 !== 1 || mem_q.size() != 0) begin
      n_fail++; $display("FAIL rst_refetch: got fills=%0d pending=%0d, required 1/0", fl2, mem_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_miss();
    test_wait_states();
    test_store();
    test_hit();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
